// File: rtl/rce_msg_framer.sv
// rce_msg_framer: packs a gated serial message into K-bit words,
// tags them with a block index and buffers them 2-deep.
module rce_msg_framer #(
  parameter int K = 32,
  parameter int NBLK = 32,
  parameter bit MSB_FIRST = 1'b1,
  parameter int IW = $clog2(NBLK)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 msg,
  input  logic                 datavalid,
  output logic [K-1:0]         out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW-1:0]        out_idx,
  output logic                 out_first,
  output logic                 out_last,
  output logic [$clog2(K)-1:0] bit_cnt,
  output logic                 overflow
);

  localparam int BW = $clog2(K);

  typedef struct packed {
    logic [K-1:0]  data;
    logic [IW-1:0] idx;
  } ent_t;

  logic [K-1:0]  sh;
  logic [K-1:0]  sh_nxt;
  logic [IW-1:0] widx;
  ent_t          hd;
  ent_t          tl;
  ent_t          wr;
  logic          hd_vld;
  logic          tl_vld;
  logic          done;
  logic          pop;

  always_comb begin
    if (MSB_FIRST) sh_nxt = {sh[K-2:0], msg};
    else           sh_nxt = {msg, sh[K-1:1]};
  end

  assign done = datavalid && (bit_cnt == BW'(K-1));
  assign pop  = hd_vld && out_ready;
  assign wr   = '{data: sh_nxt, idx: widx};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh       <= '0;
      bit_cnt  <= '0;
      widx     <= '0;
      hd       <= '0;
      tl       <= '0;
      hd_vld   <= 1'b0;
      tl_vld   <= 1'b0;
      overflow <= 1'b0;
    end else if (clr) begin
      sh       <= '0;
      bit_cnt  <= '0;
      widx     <= '0;
      hd.idx   <= '0;
      hd_vld   <= 1'b0;
      tl_vld   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (datavalid) begin
        sh      <= sh_nxt;
        bit_cnt <= done ? '0 : bit_cnt + 1'b1;
      end
      // index advances even on a drop to keep block framing aligned
      if (done) begin
        widx <= (widx == IW'(NBLK-1)) ? '0 : widx + 1'b1;
      end
      unique case (1'b1)
        !hd_vld: begin
          if (done) begin
            hd     <= wr;
            hd_vld <= 1'b1;
          end
        end
        hd_vld && !tl_vld: begin
          if (pop && done) begin
            hd <= wr;
          end else if (pop) begin
            hd_vld <= 1'b0;
          end else if (done) begin
            tl     <= wr;
            tl_vld <= 1'b1;
          end
        end
        hd_vld && tl_vld: begin
          if (pop) begin
            hd     <= tl;
            tl_vld <= done;
            if (done) tl <= wr;
          end else if (done) begin
            overflow <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data  = hd.data;
  assign out_idx   = hd.idx;
  assign out_valid = hd_vld;
  assign out_first = hd_vld && (hd.idx == '0);
  assign out_last  = hd_vld && (hd.idx == IW'(NBLK-1));

endmodule

// File: tb/tb_rce_msg_framer.sv
// tb_rce_msg_framer: scenario tasks against a queue-based model,
// with MSB-first and LSB-first instances fed the same stream.
module tb_rce_msg_framer;

  localparam int NB = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic msg = 1'b0;
  logic datavalid = 1'b0;
  logic out_ready = 1'b0;

  logic [31:0] m_data, l_data;
  logic        m_valid, l_valid;
  logic [4:0]  m_idx, l_idx, m_cnt, l_cnt;
  logic        m_first, l_first, m_last, l_last;
  logic        m_ovf, l_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rce_msg_framer #(.K(32), .NBLK(NB), .MSB_FIRST(1'b1)) u_m (
    .clk(clk), .rst(rst), .clr(clr), .msg(msg),
    .datavalid(datavalid), .out_data(m_data),
    .out_valid(m_valid), .out_ready(out_ready),
    .out_idx(m_idx), .out_first(m_first),
    .out_last(m_last), .bit_cnt(m_cnt),
    .overflow(m_ovf)
  );

  rce_msg_framer #(.K(32), .NBLK(NB), .MSB_FIRST(1'b0)) u_l (
    .clk(clk), .rst(rst), .clr(clr), .msg(msg),
    .datavalid(datavalid), .out_data(l_data),
    .out_valid(l_valid), .out_ready(out_ready),
    .out_idx(l_idx), .out_first(l_first),
    .out_last(l_last), .bit_cnt(l_cnt),
    .overflow(l_ovf)
  );

  typedef struct packed {
    logic [31:0] m;
    logic [31:0] l;
    logic [7:0]  idx;
  } ent_t;

  ent_t        q[$];
  int          pcnt;
  logic [31:0] pm, pl;
  int          widx;
  bit          ovf;

  function automatic logic [31:0] rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    pcnt = 0;
    widx = 0;
    ovf  = 1'b0;
    pm   = '0;
    pl   = '0;
  endtask

  // Word-level model: bits collect into a word, completed words
  // join a queue of depth two after the consumer has taken one.
  task automatic model_step(bit b, bit dv, bit rdy, bit c);
    if (c) begin
      model_reset();
      return;
    end
    if (q.size() > 0 && rdy) void'(q.pop_front());
    if (dv) begin
      pm[31-pcnt] = b;
      pl[pcnt]    = b;
      pcnt++;
      if (pcnt == 32) begin
        if (q.size() < 2) q.push_back('{pm, pl, 8'(widx)});
        else ovf = 1'b1;
        widx = (widx + 1) % NB;
        pcnt = 0;
      end
    end
  endtask

  task automatic step(bit b, bit dv, bit rdy, bit c);
    msg = b;
    datavalid = dv;
    out_ready = rdy;
    clr = c;
    @(posedge clk);
    #1;
    model_step(b, dv, rdy, c);
  endtask

  task automatic send(input logic [31:0] w, input bit rdy);
    for (int i = 0; i < 32; i++) step(w[31-i], 1'b1, rdy, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({m_valid, m_first, m_last, m_idx, m_cnt, m_ovf, m_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_m got %h/%h/%h/%h want all 0",
               m_valid, m_idx, m_cnt, m_data);
    end
    n_cmp++;
    if ({l_valid, l_first, l_last, l_idx, l_cnt, l_ovf, l_data} !== '0) begin
      n_bad++;
      $display("FAIL reset_l got %h/%h/%h/%h want all 0",
               l_valid, l_idx, l_cnt, l_data);
    end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_stream();
    logic [31:0] w0, w1;
    w0 = 32'hD9DA7BEA;
    w1 = 32'h1A31D8AB;
    for (int i = 0; i < 31; i++) step(w0[31-i], 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stream_early got %b want 0", m_valid);
    end
    step(w0[0], 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({m_valid, m_first, m_idx, m_data} !== {2'b11, 5'd0, w0}) begin
      n_bad++;
      $display("FAIL stream_w0 got v%b f%b i%0d %h want v1 f1 i0 %h",
               m_valid, m_first, m_idx, m_data, w0);
    end
    n_cmp++;
    if (l_data !== rev(w0)) begin
      n_bad++;
      $display("FAIL stream_w0_lsb got %h want %h", l_data, rev(w0));
    end
    send(w1, 1'b1);
    n_cmp++;
    if ({m_valid, m_first, m_idx, m_data, m_ovf} !== {2'b10, 5'd1, w1, 1'b0}) begin
      n_bad++;
      $display("FAIL stream_w1 got v%b f%b i%0d %h o%b want v1 f0 i1 %h o0",
               m_valid, m_first, m_idx, m_data, m_ovf, w1);
    end
  endtask

  task automatic test_block_wrap();
    logic [31:0] w;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int wi = 0; wi < 33; wi++) begin
      w = (wi == 0) ? 32'hD9DA7BEA : (wi == 1) ? 32'h1A31D8AB : $urandom;
      send(w, 1'b1);
      n_cmp++;
      if (!m_valid || m_data !== w || l_data !== rev(w)
          || m_idx !== 5'(wi % NB)) begin
        n_bad++;
        $display("FAIL wrap_word%0d got v%b i%0d %h/%h want i%0d %h",
                 wi, m_valid, m_idx, m_data, l_data, wi % NB, w);
      end
      n_cmp++;
      if (m_last !== (wi == 31) || m_first !== (wi % NB == 0)) begin
        n_bad++;
        $display("FAIL wrap_flags%0d got f%b l%b want f%b l%b",
                 wi, m_first, m_last, wi % NB == 0, wi == 31);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] w2, w3;
    w2 = $urandom;
    w3 = $urandom;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send(32'hD9DA7BEA, 1'b0);
    send(32'h1A31D8AB, 1'b0);
    send(w2, 1'b0);
    n_cmp++;
    if ({m_ovf, m_valid, m_idx, m_data} !== {2'b11, 5'd0, 32'hD9DA7BEA}
        || m_ovf !== ovf) begin
      n_bad++;
      $display("FAIL ovf_hold got o%b v%b i%0d %h want o1 v1 i0 d9da7bea",
               m_ovf, m_valid, m_idx, m_data);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({m_valid, m_idx, m_data} !== {1'b1, 5'd1, 32'h1A31D8AB}) begin
      n_bad++;
      $display("FAIL ovf_pop1 got v%b i%0d %h want v1 i1 1a31d8ab",
               m_valid, m_idx, m_data);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (m_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_pop2 got v%b want 0", m_valid);
    end
    send(w3, 1'b1);
    n_cmp++;
    if ({m_valid, m_idx, m_data, m_ovf} !== {1'b1, 5'd3, w3, 1'b1}) begin
      n_bad++;
      $display("FAIL ovf_next got v%b i%0d %h o%b want v1 i3 %h o1",
               m_valid, m_idx, m_data, m_ovf, w3);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] a, b, c;
    a = $urandom;
    b = $urandom;
    c = $urandom;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send(a, 1'b0);
    send(b, 1'b0);
    for (int i = 0; i < 31; i++) step(c[31-i], 1'b1, 1'b0, 1'b0);
    step(c[0], 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({m_ovf, m_valid, m_idx, m_data} !== {2'b01, 5'd1, b}) begin
      n_bad++;
      $display("FAIL full_pop got o%b v%b i%0d %h want o0 v1 i1 %h",
               m_ovf, m_valid, m_idx, m_data, b);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({m_valid, m_idx, m_data} !== {1'b1, 5'd2, c}) begin
      n_bad++;
      $display("FAIL full_pop_c got v%b i%0d %h want v1 i2 %h",
               m_valid, m_idx, m_data, c);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (m_valid !== 1'b0 || m_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL full_pop_end got v%b o%b want v0 o0", m_valid, m_ovf);
    end
  endtask

  task automatic test_gaps();
    logic [31:0] w, w2, w3;
    w  = $urandom;
    w2 = $urandom;
    w3 = $urandom;
    for (int i = 0; i < 32; i++) begin
      step(w[31-i], 1'b1, 1'b1, 1'b0);
      if (i == 31) begin
        n_cmp++;
        if (!m_valid || m_data !== w || l_data !== rev(w)
            || m_idx !== q[0].idx[4:0]) begin
          n_bad++;
          $display("FAIL gap_word got v%b i%0d %h want i%0d %h",
                   m_valid, m_idx, m_data, q[0].idx, w);
        end
      end
      step(1'b0, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (m_cnt !== 5'(pcnt) || l_cnt !== 5'(pcnt)) begin
        n_bad++;
        $display("FAIL gap_cnt%0d got %0d want %0d", i, m_cnt, pcnt);
      end
    end
    for (int i = 0; i < 17; i++) step(w2[31-i], 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (m_cnt !== 5'd17) begin
      n_bad++;
      $display("FAIL clr_pre got %0d want 17", m_cnt);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if ({m_cnt, m_valid, m_idx, m_ovf} !== '0) begin
      n_bad++;
      $display("FAIL clr_post got c%0d v%b i%0d o%b want all 0",
               m_cnt, m_valid, m_idx, m_ovf);
    end
    send(w3, 1'b1);
    n_cmp++;
    if ({m_valid, m_idx, m_data} !== {1'b1, 5'd0, w3} || l_data !== rev(w3)) begin
      n_bad++;
      $display("FAIL clr_word got v%b i%0d %h/%h want v1 i0 %h",
               m_valid, m_idx, m_data, l_data, w3);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] w;
    w = $urandom;
    send(32'hD9DA7BEA, 1'b0);
    for (int i = 0; i < 10; i++) step(w[31-i], 1'b1, 1'b0, 1'b0);
    datavalid = 1'b0;
    n_cmp++;
    if (m_valid !== 1'b1 || m_cnt !== 5'd10) begin
      n_bad++;
      $display("FAIL arst_pre got v%b c%0d want v1 c10", m_valid, m_cnt);
    end
    #3 rst = 1'b0;
    #1;
    n_cmp++;
    if ({m_valid, m_idx, m_cnt, m_ovf, m_data,
         l_valid, l_idx, l_cnt, l_ovf, l_data} !== '0) begin
      n_bad++;
      $display("FAIL arst_now got v%b c%0d %h / v%b %h want all 0",
               m_valid, m_cnt, m_data, l_valid, l_data);
    end
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    send(32'hD9DA7BEA, 1'b1);
    n_cmp++;
    if ({m_valid, m_first, m_idx, m_data} !== {2'b11, 5'd0, 32'hD9DA7BEA}) begin
      n_bad++;
      $display("FAIL arst_msb got v%b f%b i%0d %h want v1 f1 i0 d9da7bea",
               m_valid, m_first, m_idx, m_data);
    end
    n_cmp++;
    if ({l_valid, l_idx, l_data} !== {1'b1, 5'd0, 32'h57DE5B9B}) begin
      n_bad++;
      $display("FAIL arst_lsb got v%b i%0d %h want v1 i0 57de5b9b",
               l_valid, l_idx, l_data);
    end
  endtask

  task automatic test_random();
    bit b, dv, rdy, c;
    int errs;
    errs = 0;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      b   = 1'($urandom);
      dv  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      c   = ($urandom_range(0, 399) == 0);
      step(b, dv, rdy, c);
      n_cmp++;
      if (m_valid !== (q.size() > 0) || l_valid !== (q.size() > 0)
          || m_cnt !== 5'(pcnt) || m_ovf !== ovf || l_ovf !== ovf) begin
        n_bad++;
        if (errs++ < 10)
          $display("FAIL rand_ctl%0d got v%b c%0d o%b want v%b c%0d o%b",
                   cyc, m_valid, m_cnt, m_ovf, q.size() > 0, pcnt, ovf);
      end else if (q.size() > 0) begin
        n_cmp++;
        if (m_data !== q[0].m || l_data !== q[0].l
            || m_idx !== q[0].idx[4:0] || m_first !== (q[0].idx == 0)
            || m_last !== (q[0].idx == NB - 1)) begin
          n_bad++;
          if (errs++ < 10)
            $display("FAIL rand_dat%0d got %h/%h i%0d want %h/%h i%0d",
                     cyc, m_data, l_data, m_idx, q[0].m, q[0].l, q[0].idx);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_block_wrap();
    test_overflow();
    test_full_pop();
    test_gaps();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
